// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - issue-side job sequencer for the 16-bit / dual-8-bit MAC (optional feature: MAC_SEQ_ZERO_SKIP_EN)
module mac_sequencer #(
    parameter int LEN_W        = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_multiplier,
    input  logic [15:0]      op_multiplicand,
    output logic [2:0]       mac_instruction,
    output logic [15:0]      mac_multiplier,
    output logic [15:0]      mac_multiplicand,
    output logic             mac_stall,
    input  logic [31:0]      mac_result,
    input  logic [7:0]       mac_protect,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [7:0]       res_protect,
    output logic             busy
);

    localparam int DW = $clog2(DRAIN_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    // Low two opcode bits; bit 2 is the latched mode (dual-8 forms are +4)
    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_MAC   = 2'd2;
    localparam logic [1:0] OP_SAT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FIRST, S_ACC, S_SAT, S_DRAIN, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_nxt;
    logic [DW-1:0]    r_drain;
    logic [DW-1:0]    w_drain_nxt;
    logic [2:0]       r_mac_instruction;
    logic [2:0]       w_instr_nxt;
    logic [15:0]      r_mac_multiplier;
    logic [15:0]      w_mul_nxt;
    logic [15:0]      r_mac_multiplicand;
    logic [15:0]      w_mcand_nxt;
    logic             r_mac_stall;
    logic             w_stall_nxt;
    logic             w_capture;
    logic             w_skip;
    logic [31:0]      r_res_data;
    logic [7:0]       r_res_protect;

`ifdef MAC_SEQ_ZERO_SKIP_EN
    logic w_zero16;
    logic w_zero_l0;
    logic w_zero_l1;
    assign w_zero16  = (op_multiplier == 16'd0) || (op_multiplicand == 16'd0);
    assign w_zero_l0 = (op_multiplier[7:0] == 8'd0) || (op_multiplicand[7:0] == 8'd0);
    assign w_zero_l1 = (op_multiplier[15:8] == 8'd0) || (op_multiplicand[15:8] == 8'd0);
    // Dual-8 pairs are only skippable when both lanes contribute nothing
    assign w_skip    = r_mode ? (w_zero_l0 && w_zero_l1) : w_zero16;
`else
    assign w_skip    = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and next value of the registered MAC bundle, counters and capture strobe
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_drain_nxt     = r_drain;
        w_instr_nxt     = r_mac_instruction;
        w_mul_nxt       = r_mac_multiplier;
        w_mcand_nxt     = r_mac_multiplicand;
        w_stall_nxt     = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_instr_nxt = {r_mode, OP_CLEAR};
                w_state_nxt = (r_len == '0) ? S_SAT : S_FIRST;
            end
            S_FIRST: begin
                if (op_valid) begin
                    w_instr_nxt     = {r_mode, OP_MUL};
                    w_mul_nxt       = op_multiplier;
                    w_mcand_nxt     = op_multiplicand;
                    w_remaining_nxt = r_len - LEN_W'(1);
                    w_state_nxt     = (r_len == LEN_W'(1)) ? S_SAT : S_ACC;
                end else begin
                    w_stall_nxt = 1'b1;
                end
            end
            S_ACC: begin
                if (op_valid) begin
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (w_skip) begin
                        w_stall_nxt = 1'b1;
                    end else begin
                        w_instr_nxt = {r_mode, OP_MAC};
                        w_mul_nxt   = op_multiplier;
                        w_mcand_nxt = op_multiplicand;
                    end
                    if (r_remaining == LEN_W'(1)) w_state_nxt = S_SAT;
                end else begin
                    w_stall_nxt = 1'b1;
                end
            end
            S_SAT: begin
                w_instr_nxt = {r_mode, OP_SAT};
                w_drain_nxt = '0;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_instr_nxt = {r_mode, OP_SAT};
                if (r_drain == DRAIN_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_nxt = r_drain + DW'(1);
                end
            end
            S_DONE: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job latch, counters, aligned MAC output bundle and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode             <= 1'b0;
            r_len              <= '0;
            r_remaining        <= '0;
            r_drain            <= '0;
            r_mac_instruction  <= 3'd0;
            r_mac_multiplier   <= 16'd0;
            r_mac_multiplicand <= 16'd0;
            r_mac_stall        <= 1'b0;
            r_res_data         <= 32'd0;
            r_res_protect      <= 8'd0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_mode <= cmd_mode;
                r_len  <= cmd_len;
            end
            r_remaining        <= w_remaining_nxt;
            r_drain            <= w_drain_nxt;
            r_mac_instruction  <= w_instr_nxt;
            r_mac_multiplier   <= w_mul_nxt;
            r_mac_multiplicand <= w_mcand_nxt;
            r_mac_stall        <= w_stall_nxt;
            if (w_capture) begin
                r_res_data    <= mac_result;
                r_res_protect <= mac_protect;
            end
        end
    end

    // cmd_ready is held off while reset is asserted so nothing is accepted before release
    assign cmd_ready        = (r_state == S_IDLE) && !reset;
    assign op_ready         = (r_state == S_FIRST) || (r_state == S_ACC);
    assign res_valid        = (r_state == S_DONE);
    assign busy             = (r_state != S_IDLE);
    assign mac_instruction  = r_mac_instruction;
    assign mac_multiplier   = r_mac_multiplier;
    assign mac_multiplicand = r_mac_multiplicand;
    assign mac_stall        = r_mac_stall;
    assign res_data         = r_res_data;
    assign res_protect      = r_res_protect;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed self-checking bench for mac_sequencer with a behavioural MAC
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [7:0]  cmd_len;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_multiplier;
    logic [15:0] op_multiplicand;
    logic [2:0]  mac_instruction;
    logic [15:0] mac_multiplier;
    logic [15:0] mac_multiplicand;
    logic        mac_stall;
    logic [31:0] mac_result;
    logic [7:0]  mac_protect;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_protect;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_cnt = 0;
    logic mon_en = 1'b0;
    logic [15:0] pa [8];
    logic [15:0] pb [8];

`ifdef MAC_SEQ_ZERO_SKIP_EN
    localparam int ZS_STALLS = 1;
`else
    localparam int ZS_STALLS = 0;
`endif

    mac_sequencer #(.LEN_W(8), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_multiplier(op_multiplier), .op_multiplicand(op_multiplicand),
        .mac_instruction(mac_instruction), .mac_multiplier(mac_multiplier),
        .mac_multiplicand(mac_multiplicand), .mac_stall(mac_stall),
        .mac_result(mac_result), .mac_protect(mac_protect),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_protect(res_protect), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_en && mac_stall) stall_cnt = stall_cnt + 1;

    // Behavioural MAC: executes the registered instruction on each unstalled edge
    function automatic logic signed [39:0] sat40(input logic signed [39:0] v);
        if (v > 40'sh007FFFFFFF) return 40'sh007FFFFFFF;
        if (v < 40'shFF80000000) return 40'shFF80000000;
        return v;
    endfunction
    function automatic logic signed [19:0] sat20(input logic signed [19:0] v);
        if (v > 20'sd32767) return 20'sd32767;
        if (v < -20'sd32768) return -20'sd32768;
        return v;
    endfunction

    logic signed [39:0] m_acc;
    logic signed [19:0] m_l0, m_l1;
    logic signed [31:0] w_p16;
    logic signed [15:0] w_p0, w_p1;
    logic signed [39:0] w_s40;
    logic signed [19:0] w_s0, w_s1;
    assign w_p16 = $signed(mac_multiplier) * $signed(mac_multiplicand);
    assign w_p0  = $signed(mac_multiplier[7:0]) * $signed(mac_multiplicand[7:0]);
    assign w_p1  = $signed(mac_multiplier[15:8]) * $signed(mac_multiplicand[15:8]);
    assign w_s40 = sat40(m_acc);
    assign w_s0  = sat20(m_l0);
    assign w_s1  = sat20(m_l1);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc <= '0; m_l0 <= '0; m_l1 <= '0; mac_result <= '0; mac_protect <= '0;
        end else if (!mac_stall) begin
            case (mac_instruction)
                3'd0: m_acc <= '0;
                3'd1: m_acc <= {{8{w_p16[31]}}, w_p16};
                3'd2: m_acc <= m_acc + {{8{w_p16[31]}}, w_p16};
                3'd3: begin mac_result <= w_s40[31:0]; mac_protect <= w_s40[39:32]; end
                3'd4: begin m_l0 <= '0; m_l1 <= '0; end
                3'd5: begin m_l0 <= {{4{w_p0[15]}}, w_p0}; m_l1 <= {{4{w_p1[15]}}, w_p1}; end
                3'd6: begin m_l0 <= m_l0 + {{4{w_p0[15]}}, w_p0}; m_l1 <= m_l1 + {{4{w_p1[15]}}, w_p1}; end
                default: begin
                    mac_result  <= {w_s1[15:0], w_s0[15:0]};
                    mac_protect <= {w_s1[19:16], w_s0[19:16]};
                end
            endcase
        end
    end

    // Present one pair and hold it until the edge on which op_ready is sampled high
    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        int t;
        op_valid = 1'b1; op_multiplier = a; op_multiplicand = b;
        t = 0;
        while (!op_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin
            n_vec++; n_err++;
            $display("FAIL op_ready_timeout got op_ready=%0b required 1", op_ready);
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic run_job(input string name, input logic mode, input int len,
                           input int bubble_after, input int bubbles, input int hold,
                           input logic [31:0] exp_data, input logic [7:0] exp_prot,
                           input int exp_lat, input int exp_stalls);
        int e0, t, lat;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_cmd_ready_idle got %0b required 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_mode = mode; cmd_len = 8'(len);
        stall_cnt = 0; mon_en = 1'b1; e0 = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            send_pair(pa[k], pb[k]);
            if (k == bubble_after) repeat (bubbles) @(negedge clk);
        end
        t = 0;
        while (!res_valid && t < 200) begin @(negedge clk); t++; end
        mon_en = 1'b0;
        n_vec++;
        if (t >= 200) begin
            n_err++; $display("FAIL %s_res_valid_timeout got 0 required 1", name);
            return;
        end
        lat = cyc - e0;
        n_vec++;
        if (lat !== exp_lat) begin
            n_err++; $display("FAIL %s_latency got E%0d required E%0d", name, lat, exp_lat);
        end
        n_vec++;
        if (res_data !== exp_data) begin
            n_err++; $display("FAIL %s_res_data got %h required %h", name, res_data, exp_data);
        end
        n_vec++;
        if (res_protect !== exp_prot) begin
            n_err++; $display("FAIL %s_res_protect got %h required %h", name, res_protect, exp_prot);
        end
        n_vec++;
        if (stall_cnt !== exp_stalls) begin
            n_err++; $display("FAIL %s_stall_cycles got %0d required %0d", name, stall_cnt, exp_stalls);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_vec++;
            if (res_data !== exp_data || res_valid !== 1'b1 || cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s_hold%0d got data=%h valid=%0b cmd_ready=%0b required %h 1 0",
                         name, h, res_data, res_valid, cmd_ready, exp_data);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        n_vec++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after_transfer got cmd_ready=%0b res_valid=%0b busy=%0b required 1 0 0",
                     name, cmd_ready, res_valid, busy);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0 ||
            mac_instruction !== 3'd0 || mac_stall !== 1'b0 || res_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state got cmd_ready=%0b busy=%0b instr=%0d stall=%0b res=%h required all 0",
                     cmd_ready, busy, mac_instruction, mac_stall, res_data);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_cmd_ready got %0b required 1", cmd_ready);
        end
    endtask

    task automatic load_s1;
        pa[0] = 16'd2;    pb[0] = 16'd3;
        pa[1] = 16'hFFFC; pb[1] = 16'd5;
        pa[2] = 16'd100;  pb[2] = 16'd100;
    endtask

    task automatic test_basic;
        load_s1();
        run_job("basic", 1'b0, 3, -1, 0, 0, 32'd9986, 8'h00, 9, 0);
    endtask

    task automatic test_dual;
        pa[0] = 16'h0302; pb[0] = 16'h0405;
        pa[1] = 16'h01FF; pb[1] = 16'h0102;
        run_job("dual", 1'b1, 2, -1, 0, 0, 32'h000D_0008, 8'h00, 8, 0);
    endtask

    task automatic test_bubbles;
        load_s1();
        run_job("bubbles", 1'b0, 3, 0, 3, 0, 32'd9986, 8'h00, 12, 3);
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 3; k++) begin pa[k] = 16'h8000; pb[k] = 16'h8000; end
        run_job("saturate", 1'b0, 3, -1, 0, 0, 32'h7FFF_FFFF, 8'h00, 9, 0);
    endtask

    task automatic test_len_zero;
        run_job("len_zero", 1'b0, 0, -1, 0, 0, 32'd0, 8'h00, 6, 0);
    endtask

    task automatic test_result_hold;
        load_s1();
        run_job("result_hold", 1'b0, 3, -1, 0, 5, 32'd9986, 8'h00, 9, 0);
    endtask

    task automatic test_zero_skip;
        pa[0] = 16'd2;   pb[0] = 16'd3;
        pa[1] = 16'd0;   pb[1] = 16'd7;
        pa[2] = 16'd100; pb[2] = 16'd100;
        run_job("zero_skip", 1'b0, 3, -1, 0, 0, 32'd10006, 8'h00, 9, ZS_STALLS);
    endtask

    task automatic test_reset_mid_job;
        logic seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_len = 8'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        send_pair(16'd2, 16'd3);
        send_pair(16'hFFFC, 16'd5);
        n_vec++;
        if (busy !== 1'b1 || mac_instruction !== 3'd2 || mac_multiplier !== 16'hFFFC) begin
            n_err++;
            $display("FAIL midjob_pre_reset got busy=%0b instr=%0d mul=%h required 1 2 fffc",
                     busy, mac_instruction, mac_multiplier);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (mac_instruction !== 3'd0 || mac_multiplier !== 16'd0 || mac_multiplicand !== 16'd0 ||
            mac_stall !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b0 || cmd_ready !== 1'b0 ||
            res_valid !== 1'b0 || res_data !== 32'd0 || res_protect !== 8'd0) begin
            n_err++;
            $display("FAIL midjob_reset_outputs got instr=%0d mul=%h mcand=%h stall=%0b busy=%0b res=%h required all 0",
                     mac_instruction, mac_multiplier, mac_multiplicand, mac_stall, busy, res_data);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (res_valid) seen = 1'b1; end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL midjob_no_result got res_valid=%0b required 0", seen);
        end
        load_s1();
        run_job("after_reset", 1'b0, 3, -1, 0, 0, 32'd9986, 8'h00, 9, 0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = 8'd0;
        op_valid = 1'b0; op_multiplier = 16'd0; op_multiplicand = 16'd0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_dual();
        test_bubbles();
        test_saturate();
        test_len_zero();
        test_result_hold();
        test_zero_skip();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
